// File: rtl/ibex_rf_ctrl_pkg.sv
// ibex_rf_ctrl_pkg
//   Shared types for the register-file write-port controller.
//   - rf_wport_state_e : controller states (IDLE, CLEAR, FORCE)
//   - rf_wr_req_t      : one write request {we, waddr, wdata}
//   - rf_num_words()   : architectural register count for RV32E / RV32I
//   wdata in rf_wr_req_t is sized for the widest supported register
//   (RfMaxDataWidth); narrower instances use the low DataWidth bits.
package ibex_rf_ctrl_pkg;

    localparam int unsigned RfAddrWidth    = 5;
    localparam int unsigned RfMaxDataWidth = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FORCE = 2'd2
    } rf_wport_state_e;

    typedef struct packed {
        logic                      we;
        logic [RfAddrWidth-1:0]    waddr;
        logic [RfMaxDataWidth-1:0] wdata;
    } rf_wr_req_t;

    function automatic int unsigned rf_num_words(input bit rv32e);
        return rv32e ? 16 : 32;
    endfunction

endpackage

// File: rtl/ibex_rf_wport_ctrl_starve.sv
// ibex_rf_starve_cnt
//   Saturating 4-bit count of consecutive cycles in which the secondary
//   requester lost arbitration.
//   Ports:
//     clk_i   clock
//     rst_ni  asynchronous active-low reset
//     inc_i   request lost this cycle
//     clr_i   request granted or withdrawn this cycle (wins over inc_i)
//     hit_o   the value being loaded this cycle reaches MaxStarve
//   hit_o looks at the next count so the controller can switch to FORCE on
//   the same edge that records the MaxStarve-th lost cycle.
module ibex_rf_starve_cnt #(
    parameter int unsigned MaxStarve = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic hit_o
);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr_i) begin
            cnt_next = 4'd0;
        end else if (inc_i && (cnt_reg != 4'hF)) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    assign hit_o = (cnt_next >= 4'(MaxStarve));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/ibex_rf_wport_ctrl.sv
// ibex_rf_wport_ctrl
//   Arbitrates the register file's single write port between the core
//   writeback path (primary) and a debug/abstract-command requester
//   (secondary), and runs a hardware sequence that writes WordZeroVal to
//   every architectural register x1..x(N-1).
//   Ports:
//     clk_i, rst_ni                 clock, asynchronous active-low reset
//     clear_req_i / clear_busy_o    clear request pulse / clear pending or running
//     wb_we_i, wb_waddr_i, wb_wdata_i, wb_stall_o
//                                   primary write; stall means "hold request"
//     sec_req_i, sec_waddr_i, sec_wdata_i, sec_gnt_o
//                                   secondary write, held until sec_gnt_o
//     rf_we_o, rf_waddr_o, rf_wdata_o
//                                   registered write port towards the RF
//   Build option: define IBEX_RF_CLEAR_ON_RESET_EN to start a clear
//   automatically out of reset.
module ibex_rf_wport_ctrl
    import ibex_rf_ctrl_pkg::*;
#(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0,
    parameter int unsigned          MaxStarve   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_req_i,
    output logic                 clear_busy_o,
    input  logic                 wb_we_i,
    input  logic [4:0]           wb_waddr_i,
    input  logic [DataWidth-1:0] wb_wdata_i,
    output logic                 wb_stall_o,
    input  logic                 sec_req_i,
    input  logic [4:0]           sec_waddr_i,
    input  logic [DataWidth-1:0] sec_wdata_i,
    output logic                 sec_gnt_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o
);

    localparam int unsigned NumWords = rf_num_words(RV32E);
    localparam logic [4:0]  LastAddr = 5'(NumWords - 1);

`ifdef IBEX_RF_CLEAR_ON_RESET_EN
    localparam logic ClearPendRst = 1'b1;
`else
    localparam logic ClearPendRst = 1'b0;
`endif

    rf_wport_state_e      state_reg, state_next;
    logic                 clear_pend_reg, clear_pend_next, clear_pend_eff;
    logic [4:0]           clr_addr_reg, clr_addr_next;
    logic                 rf_we_reg;
    logic [4:0]           rf_waddr_reg;
    logic [DataWidth-1:0] rf_wdata_reg;

    rf_wr_req_t acc_req;
    logic       sec_gnt, wb_stall;
    logic       starve_inc, starve_clr, starve_hit;

    // Which request owns the port this cycle. Depends only on state and
    // inputs, so it is kept apart from the next-state logic that consumes
    // the starve counter (which in turn depends on sec_gnt).
    always_comb begin
        sec_gnt  = 1'b0;
        wb_stall = 1'b0;
        acc_req  = '0;
        unique case (state_reg)
            IDLE: begin
                if (wb_we_i) begin
                    acc_req.we    = 1'b1;
                    acc_req.waddr = wb_waddr_i;
                    acc_req.wdata = RfMaxDataWidth'(wb_wdata_i);
                end else if (sec_req_i) begin
                    sec_gnt       = 1'b1;
                    acc_req.we    = 1'b1;
                    acc_req.waddr = sec_waddr_i;
                    acc_req.wdata = RfMaxDataWidth'(sec_wdata_i);
                end
            end
            FORCE: begin
                wb_stall = 1'b1;
                if (sec_req_i) begin
                    sec_gnt       = 1'b1;
                    acc_req.we    = 1'b1;
                    acc_req.waddr = sec_waddr_i;
                    acc_req.wdata = RfMaxDataWidth'(sec_wdata_i);
                end
            end
            CLEAR: begin
                wb_stall      = 1'b1;
                acc_req.we    = 1'b1;
                acc_req.waddr = clr_addr_reg;
                acc_req.wdata = RfMaxDataWidth'(WordZeroVal);
            end
            default: ;
        endcase
    end

    // Starve counter is frozen while clearing.
    assign starve_inc = (state_reg != CLEAR) & sec_req_i & ~sec_gnt;
    assign starve_clr = (state_reg != CLEAR) & (~sec_req_i | sec_gnt);

    ibex_rf_starve_cnt #(
        .MaxStarve (MaxStarve)
    ) u_starve_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (starve_inc),
        .clr_i  (starve_clr),
        .hit_o  (starve_hit)
    );

    // A clear requested during FORCE is folded in immediately, so FORCE
    // hands straight over to CLEAR and busy is visible in the FORCE cycle.
    always_comb begin
        state_next      = state_reg;
        clear_pend_next = clear_pend_reg;
        clr_addr_next   = clr_addr_reg;
        clear_pend_eff  = clear_pend_reg;
        unique case (state_reg)
            IDLE: begin
                if (clear_req_i || clear_pend_reg) begin
                    state_next      = CLEAR;
                    clear_pend_next = 1'b0;
                    clr_addr_next   = 5'd1;
                end else if (starve_hit) begin
                    state_next = FORCE;
                end
            end
            FORCE: begin
                clear_pend_eff = clear_pend_reg | clear_req_i;
                if (clear_pend_eff) begin
                    state_next      = CLEAR;
                    clear_pend_next = 1'b0;
                    clr_addr_next   = 5'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (clr_addr_reg == LastAddr) begin
                    state_next = IDLE;
                end else begin
                    clr_addr_next = clr_addr_reg + 5'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            clear_pend_reg <= ClearPendRst;
            clr_addr_reg   <= 5'd0;
            rf_we_reg      <= 1'b0;
            rf_waddr_reg   <= 5'd0;
            rf_wdata_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            clear_pend_reg <= clear_pend_next;
            clr_addr_reg   <= clr_addr_next;
            // x0 writes are consumed but never reach the register file.
            rf_we_reg      <= acc_req.we && (acc_req.waddr != 5'd0);
            if (acc_req.we) begin
                rf_waddr_reg <= acc_req.waddr;
                rf_wdata_reg <= acc_req.wdata[DataWidth-1:0];
            end
        end
    end

    generate
        if (DataWidth < RfMaxDataWidth) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^acc_req.wdata[RfMaxDataWidth-1:DataWidth];
        end
    endgenerate

    assign sec_gnt_o    = sec_gnt;
    assign wb_stall_o   = wb_stall;
    assign clear_busy_o = (state_reg == CLEAR) | clear_pend_eff;
    assign rf_we_o      = rf_we_reg;
    assign rf_waddr_o   = rf_waddr_reg;
    assign rf_wdata_o   = rf_wdata_reg;

endmodule
